// File: rtl/cordic_exp_control.sv
// Sequencing FSM for a floating-point CORDIC exp(T) datapath: clears the datapath,
// runs ITER_LAST+1 hyperbolic iterations, then forms the final sum and product.
module cordic_exp_control #(
    parameter int             D         = 5,
    parameter logic [D-1:0]   ITER_LAST = 5'd25
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BEGIN_OPERATION,
    input  logic         ACK_SUMX,
    input  logic         ACK_SUMY,
    input  logic         ACK_SUMZ,
    input  logic         ACK_MULT,
    input  logic [D-1:0] CONT_ITERA,
    output logic         RST_COPROC,
    output logic         MS_1,
    output logic [1:0]   MS_M,
    output logic [1:0]   MS_2,
    output logic         ADD_SUBT,
    output logic         Begin_SUMX,
    output logic         Begin_SUMY,
    output logic         Begin_SUMZ,
    output logic         Begin_MULT,
    output logic         EN_REG1X,
    output logic         EN_REG1Y,
    output logic         EN_REG1Z,
    output logic         EN_REG2,
    output logic         EN_REG2XYZ,
    output logic         EN_REG3,
    output logic         EN_REG4,
    output logic         CLK_CDIR,
    output logic         READY
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, INIT_Z, WAIT_Z0, LOAD_INIT, SHIFT, START_ITER,
        WAIT_ITER, UPDATE, FINAL_SUM, WAIT_FS, START_MULT, WAIT_MULT, DONE
    } state_t;

    state_t     state;
    logic [2:0] ack_flags;  // sticky {X, Y, Z} adder completions
    logic [2:0] ack_seen;

    always_comb begin
        ack_seen = ack_flags | {ACK_SUMX, ACK_SUMY, ACK_SUMZ};
    end

    function automatic logic [1:0] mant_sel(input logic [D-1:0] n);
        if (n == '0)
            return 2'b00;
        else if (n == D'(1))
            return 2'b01;
        else
            return 2'b10;
    endfunction

    // NOTE: every output is loaded together with the state it belongs to, so each
    // output is a flop and no input reaches an output without passing a clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            ack_flags  <= '0;
            RST_COPROC <= 1'b0;
            MS_1       <= 1'b0;
            MS_M       <= 2'b00;
            MS_2       <= 2'b00;
            ADD_SUBT   <= 1'b0;
            Begin_SUMX <= 1'b0;
            Begin_SUMY <= 1'b0;
            Begin_SUMZ <= 1'b0;
            Begin_MULT <= 1'b0;
            EN_REG1X   <= 1'b0;
            EN_REG1Y   <= 1'b0;
            EN_REG1Z   <= 1'b0;
            EN_REG2    <= 1'b0;
            EN_REG2XYZ <= 1'b0;
            EN_REG3    <= 1'b0;
            EN_REG4    <= 1'b0;
            CLK_CDIR   <= 1'b0;
            READY      <= 1'b0;
        end else begin
            RST_COPROC <= 1'b0;
            MS_1       <= 1'b0;
            MS_M       <= 2'b00;
            MS_2       <= 2'b00;
            ADD_SUBT   <= 1'b0;
            Begin_SUMX <= 1'b0;
            Begin_SUMY <= 1'b0;
            Begin_SUMZ <= 1'b0;
            Begin_MULT <= 1'b0;
            EN_REG1X   <= 1'b0;
            EN_REG1Y   <= 1'b0;
            EN_REG1Z   <= 1'b0;
            EN_REG2    <= 1'b0;
            EN_REG2XYZ <= 1'b0;
            EN_REG3    <= 1'b0;
            EN_REG4    <= 1'b0;
            CLK_CDIR   <= 1'b0;
            READY      <= 1'b0;

            case (state)
                IDLE: begin
                    if (BEGIN_OPERATION) begin
                        state      <= CLEAR;
                        RST_COPROC <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= INIT_Z;
                    MS_2       <= 2'b10;
                    Begin_SUMZ <= 1'b1;
                end
                INIT_Z: begin
                    state <= WAIT_Z0;
                    MS_2  <= 2'b10;
                end
                WAIT_Z0: begin
                    if (ACK_SUMZ) begin
                        state    <= LOAD_INIT;
                        MS_1     <= 1'b1;
                        EN_REG1X <= 1'b1;
                        EN_REG1Y <= 1'b1;
                        EN_REG1Z <= 1'b1;
                    end else begin
                        MS_2 <= 2'b10;
                    end
                end
                LOAD_INIT: begin
                    state      <= SHIFT;
                    EN_REG2    <= 1'b1;
                    EN_REG2XYZ <= 1'b1;
                    MS_M       <= mant_sel(CONT_ITERA);
                end
                SHIFT: begin
                    state      <= START_ITER;
                    ack_flags  <= '0;
                    MS_2       <= 2'b01;
                    Begin_SUMX <= 1'b1;
                    Begin_SUMY <= 1'b1;
                    Begin_SUMZ <= 1'b1;
                end
                START_ITER: begin
                    state <= WAIT_ITER;
                    MS_2  <= 2'b01;
                end
                WAIT_ITER: begin
                    if (&ack_seen) begin
                        state    <= UPDATE;
                        EN_REG1X <= 1'b1;
                        EN_REG1Y <= 1'b1;
                        EN_REG1Z <= 1'b1;
                        CLK_CDIR <= 1'b1;
                    end else begin
                        ack_flags <= ack_seen;
                        MS_2      <= 2'b01;
                    end
                end
                UPDATE: begin
                    if (CONT_ITERA == ITER_LAST) begin
                        state      <= FINAL_SUM;
                        Begin_SUMZ <= 1'b1;
                    end else begin
                        // The counter steps on this edge from the CLK_CDIR pulse just issued.
                        state      <= SHIFT;
                        EN_REG2    <= 1'b1;
                        EN_REG2XYZ <= 1'b1;
                        MS_M       <= mant_sel(CONT_ITERA + D'(1));
                    end
                end
                FINAL_SUM: begin
                    state <= WAIT_FS;
                end
                WAIT_FS: begin
                    if (ACK_SUMZ) begin
                        state      <= START_MULT;
                        EN_REG3    <= 1'b1;
                        Begin_MULT <= 1'b1;
                    end
                end
                START_MULT: begin
                    state <= WAIT_MULT;
                end
                WAIT_MULT: begin
                    if (ACK_MULT) begin
                        state   <= DONE;
                        EN_REG4 <= 1'b1;
                        READY   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!BEGIN_OPERATION)
                        state <= IDLE;
                    else
                        READY <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
